prog_mem_loader: RTL and testbench
==================================

# prog_mem_loader

Writer side of the 256 x 8 program memory. It accepts a byte stream over a valid/ready handshake and writes it into an internal RAM: the run starts at a programmed base address and covers a programmed length. It provides the run-time alternative to file preload. A start/busy/done control handshake lets a sequencer FSM launch loads, and a synchronous read port serves the consumer.

## Interface
- ADDR_W, 8, address width; memory depth is 2**ADDR_W
- DATA_W, 8, byte width
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- base_addr  in  ADDR_W  first write address; latched on accepted start
- length  in  ADDR_W+1  byte count, 0..256; latched on accepted start
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader can accept a byte
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, run complete
- len_err  out  1  one-cycle pulse, start with length==0
- wr_count  out  ADDR_W+1  bytes written in current/last run
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE -> LOAD when start=1 and length!=0; base_addr and length are latched; wr_count is cleared.
- IDLE with start=1 and length==0: len_err=1 for one cycle; state stays IDLE; nothing is latched; no writes.
- LOAD -> WRITE unconditionally; this is a single setup cycle.
- In WRITE, in_ready=1. A transfer occurs on a cycle where in_valid & in_ready: mem[addr] <= in_data, addr <= addr+1, remaining <= remaining-1, wr_count <= wr_count+1.
- WRITE -> DONE on the transfer where remaining==1.
- DONE -> IDLE unconditionally; done=1 only in DONE.
- Address arithmetic is modulo 2**ADDR_W: base 0xFE, length 4 writes 0xFE, 0xFF, 0x00, 0x01. length==256 writes every location exactly once.
- start while busy is ignored; it is not queued.
- in_valid outside WRITE is ignored; in_data is don't-care.
- in_valid may drop at any cycle in WRITE; the loader waits without a timeout.
- in_ready is a pure decode of state. It has no combinational path from in_valid.
- Read port: rd_data <= mem[rd_addr] every cycle. It is read-before-write, so a same-cycle write to rd_addr returns the old byte, and the new byte appears one cycle later.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, len_err=0, wr_count=0, rd_data=0.
- Memory contents are not reset.
- rst asserted mid-run aborts immediately: no done pulse, and bytes already written stay in memory.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: LOAD, busy=1. Cycle 2: WRITE, in_ready=1.
- Throughput is one byte per cycle with in_valid held high.
- For an N-byte run with in_valid held high from cycle 2:
  - the last transfer is in cycle N+1;
  - done=1 in cycle N+2;
  - IDLE in cycle N+3, where a new start is accepted.
- in_ready falls in the cycle after the last transfer.
- len_err is asserted in the cycle after sampling; busy stays 0.
- rd_data latency is 1 cycle.

## Structure
- Package prog_loader_pkg holds:
  - state_t enum with IDLE=2'b00, LOAD=2'b01, WRITE=2'b10, DONE=2'b11;
  - localparams ADDR_W=8, DATA_W=8 and DEPTH=256.
- Sub-module ram_1w1r (parameterised ADDR_W/DATA_W):
  - one synchronous write port and one registered read port;
  - read-before-write;
  - no reset on the storage array.
- Top level: FSM, address/remaining/wr_count counters, and handshake decode.

## Test plan
- Reset, then start with base=0x10, length=4 and stream 0xA1,0xB2,0xC3,0xD4 back-to-back -> mem[0x10..0x13]=A1,B2,C3,D4; done in cycle 6; wr_count=4; readback gives each byte 1 cycle after rd_addr.
- base=0xFE, length=4, bytes 01..04 -> mem[0xFE]=01, mem[0xFF]=02, mem[0x00]=03, mem[0x01]=04; mem[0x02] unchanged.
- length=0 with start -> len_err pulse for one cycle; busy stays 0; in_ready stays 0; memory unchanged.
- length=3 with in_valid toggling 1,0,0,1,0,1, plus start pulsed during WRITE -> exactly 3 writes to consecutive addresses; done is asserted only after the 3rd transfer; the extra start is ignored.
- rst asserted after 2 of 5 bytes -> all outputs at reset values in the same cycle; no done; the 2 written bytes are readable; a following run with length=1 works normally.
- length=256 from base 0x80 with data = address ^ 0x5A -> every location is correct; done occurs in cycle 258.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader_pkg
// Brief   : Shared types and sizes for the program-memory loader.
// Revision: 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_1w1r.sv
`default_nettype none
// ============================================================================
// Module  : ram_1w1r
// Brief   : One synchronous write port, one registered read-before-write port.
// Revision: 1.0 - initial release
// ============================================================================
module ram_1w1r #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Storage is deliberately unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_mem_loader
// Brief   : Streams a byte run into program memory from a latched base/length.
// Revision: 1.0 - initial release
// ============================================================================
module prog_mem_loader #(
    parameter int ADDR_W = prog_loader_pkg::ADDR_W,
    parameter int DATA_W = prog_loader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic [ADDR_W:0]   wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    import prog_loader_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              start_ok;
    logic              xfer;

    assign start_ok = (state == IDLE) && start && (length != '0);
    assign xfer     = in_valid && (state == WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            wr_count  <= '0;
            len_err   <= 1'b0;
        end else begin
            state   <= state_next;
            len_err <= (state == IDLE) && start && (length == '0);
            if (start_ok) begin
                addr      <= base_addr;
                remaining <= length;
                wr_count  <= '0;
            end else if (xfer) begin
                // Address wraps naturally at 2**ADDR_W.
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
                wr_count  <= wr_count + (ADDR_W+1)'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = WRITE;
            end
            WRITE: begin
                in_ready = 1'b1;
                if (xfer && (remaining == (ADDR_W+1)'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    ram_1w1r #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (xfer),
        .wr_addr (addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_mem_loader
// Brief   : Directed self-checking bench for prog_mem_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic [8:0] length = 9'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       len_err;
    logic [8:0] wr_count;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;

    prog_mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err),
        .wr_count  (wr_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start sampled in cycle 0; returns positioned in cycle 1.
    task automatic launch(input logic [7:0] b, input logic [8:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL reset_len_err: got %b want 0", len_err); end
        n_cmp++; if (wr_count !== 9'd0) begin n_err++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d [4];
        d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        launch(8'h10, 9'd4);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got %b want 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_c1: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_c2: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            tick();
            if (i < 3) begin
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_early c%0d: got %b want 0", i + 3, done); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done_c6: got %b want 1", done); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_c6: got %b want 0", in_ready); end
        n_cmp++; if (wr_count !== 9'd4) begin n_err++; $display("FAIL basic_wr_count: got %0d want 4", wr_count); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_c7: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_c7: got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 8'h10 + 8'(i);
            tick();
            n_cmp++; if (rd_data !== d[i]) begin n_err++; $display("FAIL basic_read[%0d]: got %h want %h", i, rd_data, d[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] pre [3];
        logic [7:0] exp_addr [5];
        logic [7:0] exp_data [5];
        pre      = '{8'h77, 8'h88, 8'h99};
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        exp_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h99};
        // Seed 0x00..0x02 so old-vs-new bytes are observable.
        launch(8'h00, 9'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = pre[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        launch(8'hFE, 9'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            if (i == 2) rd_addr = 8'h00;
            tick();
            if (i == 2) begin
                n_cmp++; if (rd_data !== 8'h77) begin n_err++; $display("FAIL wrap_rbw_old: got %h want 77", rd_data); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (rd_data !== 8'h03) begin n_err++; $display("FAIL wrap_rbw_new: got %h want 03", rd_data); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b want 1", done); end
        tick();
        for (int i = 0; i < 5; i++) begin
            rd_addr = exp_addr[i];
            tick();
            n_cmp++; if (rd_data !== exp_data[i]) begin n_err++; $display("FAIL wrap_read[%h]: got %h want %h", exp_addr[i], rd_data, exp_data[i]); end
        end
    endtask

    task automatic test_len_zero();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        launch(8'h10, 9'd0);
        n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL lenz_pulse: got %b want 1", len_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lenz_busy_c1: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lenz_ready_c1: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL lenz_pulse_end: got %b want 0", len_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lenz_busy_c2: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lenz_ready_c2: got %b want 0", in_ready); end
        n_cmp++; if (wr_count !== 9'd4) begin n_err++; $display("FAIL lenz_wr_count: got %0d want 4", wr_count); end
        in_valid = 1'b0;
        rd_addr  = 8'h10;
        tick();
        n_cmp++; if (rd_data !== 8'hA1) begin n_err++; $display("FAIL lenz_mem: got %h want A1", rd_data); end
    endtask

    task automatic test_stall();
        logic vpat [6];
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        launch(8'h40, 9'd3);
        tick();
        for (int i = 0; i < 6; i++) begin
            in_valid  = vpat[i];
            in_data   = 8'h30 + 8'(i);
            start     = (i == 1);
            base_addr = 8'h50;
            length    = 9'd5;
            tick();
            if (i < 5) begin
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stall_done_early c%0d: got %b want 0", i + 3, done); end
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy c%0d: got %b want 1", i + 3, busy); end
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done_c8: got %b want 1", done); end
        n_cmp++; if (wr_count !== 9'd3) begin n_err++; $display("FAIL stall_wr_count: got %0d want 3", wr_count); end
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_not_queued: got %b want 0", busy); end
        rd_addr = 8'h40; tick();
        n_cmp++; if (rd_data !== 8'h30) begin n_err++; $display("FAIL stall_read40: got %h want 30", rd_data); end
        rd_addr = 8'h41; tick();
        n_cmp++; if (rd_data !== 8'h33) begin n_err++; $display("FAIL stall_read41: got %h want 33", rd_data); end
        rd_addr = 8'h42; tick();
        n_cmp++; if (rd_data !== 8'h35) begin n_err++; $display("FAIL stall_read42: got %h want 35", rd_data); end
    endtask

    task automatic test_abort();
        launch(8'h60, 9'd5);
        tick();
        in_valid = 1'b1; in_data = 8'hE0; tick();
        in_valid = 1'b1; in_data = 8'hE1; tick();
        in_data = 8'hE2;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
        n_cmp++; if (wr_count !== 9'd0) begin n_err++; $display("FAIL abort_wr_count: got %0d want 0", wr_count); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL abort_rd_data: got %h want 00", rd_data); end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done[%0d]: got %b want 0", i, done); end
        end
        rd_addr = 8'h60; tick();
        n_cmp++; if (rd_data !== 8'hE0) begin n_err++; $display("FAIL abort_read60: got %h want E0", rd_data); end
        rd_addr = 8'h61; tick();
        n_cmp++; if (rd_data !== 8'hE1) begin n_err++; $display("FAIL abort_read61: got %h want E1", rd_data); end
        launch(8'h62, 9'd1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL after_busy: got %b want 1", busy); end
        tick();
        in_valid = 1'b1; in_data = 8'h5C; tick();
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL after_done_c3: got %b want 1", done); end
        n_cmp++; if (wr_count !== 9'd1) begin n_err++; $display("FAIL after_wr_count: got %0d want 1", wr_count); end
        rd_addr = 8'h62; tick();
        n_cmp++; if (rd_data !== 8'h5C) begin n_err++; $display("FAIL after_read62: got %h want 5C", rd_data); end
    endtask

    task automatic test_full();
        logic [7:0] a;
        launch(8'h80, 9'd256);
        tick();
        for (int i = 0; i < 256; i++) begin
            a        = 8'h80 + 8'(i);
            in_valid = 1'b1;
            in_data  = a ^ 8'h5A;
            tick();
            if (i == 254) begin
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL full_done_c257: got %b want 0", done); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done_c258: got %b want 1", done); end
        n_cmp++; if (wr_count !== 9'd256) begin n_err++; $display("FAIL full_wr_count: got %0d want 256", wr_count); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_idle: got %b want 0", busy); end
        for (int i = 0; i < 256; i++) begin
            a       = 8'(i);
            rd_addr = a;
            tick();
            n_cmp++; if (rd_data !== (a ^ 8'h5A)) begin n_err++; $display("FAIL full_read[%h]: got %h want %h", a, rd_data, a ^ 8'h5A); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_stall();
        test_abort();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
